sysreg_bank: RTL
================

Name: sysreg_bank

Overview:
- Parametrised successor to the per-core system register block.
- Byte-wide register bank decoded from a small address window, with:
  - ID bytes
  - N scratch registers
  - a write-once feature-enable register (generalises the single clockport enable)
  - a keyed soft-reset pulse of configurable length
  - last-write capture and a write counter
- Sits behind the host bus decoder, which supplies single-cycle read/write strobes.

Parameters:
ADDR_W, 5, address width; minimum 5; only a[4:0] decoded, upper bits ignored
NUM_SCRATCH, 4, scratch registers at 0x08..0x08+NUM_SCRATCH-1; range 1..8
ID0, 8'h42, value read at 0x00
ID1, 8'h73, value read at 0x01
RST_KEY, 8'h52, byte written to 0x00 that triggers soft reset
RST_PULSE_LEN, 16, soft_reset high time in clk cycles; range 1..255
FEAT_W, 8, feature_enable width; range 1..8
FEAT_RESET, 0, feature_enable value after reset

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
a  in  ADDR_W  register address
d_d  in  8  write data
d_q  out  8  read data, registered
read_strobe  in  1  one-cycle read request
write_strobe  in  1  one-cycle write request
feature_enable  out  FEAT_W  write-once feature enables; bit0 = clockport enable
soft_reset  out  1  soft-reset pulse to rest of core

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - d_q = 0xFF
  - feature_enable = FEAT_RESET
  - feat_locked = 0
  - soft_reset = 0
  - scratch = 0, last_addr = 0, last_data = 0, wcount = 0
  - write-log empty
- Reset mid-pulse: soft_reset drops on the next edge.
- Read:
  - d_q updates on the edge where read_strobe=1 and holds otherwise; visible in the cycle after the strobe.
  - Unmapped addresses return 0xFF.
  - When read and write occur in the same cycle, the read returns the pre-write value.
- Write: all effects take place on the strobe edge.
- Register map:
  - 0x00
    - R: ID0.
    - W: if d_d==RST_KEY, load the pulse counter with RST_PULSE_LEN.
  - 0x01
    - R: ID1.
    - W: if !feat_locked, feature_enable <= d_d[FEAT_W-1:0] and feat_locked <= 1.
    - Otherwise the write is ignored, but is still captured by last_addr/last_data and wcount.
  - 0x03: R feature_enable, zero-extended.
  - 0x04: R last_addr = {3'b0, a[4:0]} of the most recent write.
  - 0x05: R last_data.
  - 0x06: R status = {5'b0, log_nonempty, soft_reset, feat_locked}. log_nonempty reads 0 without the feature.
  - 0x07
    - R: wcount, which counts writes and saturates at 0xFF.
    - W: any write clears wcount to 0; the clear wins over the increment.
  - 0x08+i: R/W scratch[i], for i < NUM_SCRATCH.
- Every write, to any address including unmapped ones, updates last_addr, last_data and wcount.
- Soft-reset pulse:
  - soft_reset is high in exactly the RST_PULSE_LEN cycles that start with the edge after the key-write edge.
  - A key write during a pulse reloads the counter and extends the pulse. There is no gap.
  - soft_reset does not reset this block.

Optional Feature:
- Macro: SYSREG_WRITE_LOG_EN.
- When defined: a 4-entry FIFO of {addr[4:0], data[7:0]} captures every write.
  - When full, new writes are dropped and a sticky overflow bit is set.
  - 0x10 R: {overflow, 4'b0, count[2:0]}.
  - 0x11 R: head address, zero-extended.
  - 0x12 R: head data, and pops the FIFO (pop on the strobe edge); returns 0xFF if empty.
  - 0x10 W: any write clears the FIFO and the overflow bit. This write is itself not logged.
  - Write and pop in the same cycle are both honoured.
- When undefined: 0x10..0x12 read 0xFF and no FIFO logic is built.

Decomposition:
- Package sysreg_pkg:
  - address constants: REG_ID0, REG_ID1, REG_FEAT, REG_LADDR, REG_LDATA, REG_STATUS, REG_WCNT, REG_SCRATCH_BASE, REG_LOG_*
  - STATUS bit indices
  - log-entry struct typedef
- One sub-module, sysreg_write_log: a 4-deep FIFO with count, overflow and clear, instantiated only under the macro.

Test Plan:
- Reset, then read 0x00, 0x01, 0x09, 0x06 -> d_q = 0x42, 0x73, 0x00, 0x00 one cycle after each strobe; feature_enable = 0.
- Write 0x01=0x05, then 0x01=0xFF, then read 0x03 and 0x06 -> 0x05 and 0x01; feature_enable stays 0x05; read 0x05 -> 0xFF.
- Write 0x00=0x52 at cycle T -> soft_reset high for cycles T+1..T+16; write 0x00=0x33 -> no pulse; re-key at T+10 -> high through T+26.
- Write 0x0B=0xA5, then read 0x0B and 0x04 -> 0xA5 and 0x0B; 300 writes -> 0x07 reads 0xFF; write 0x07 -> reads 0x00.
- Same-cycle read and write of 0x08 (old 0x11, new 0x22) -> d_q = 0x11; next read -> 0x22.
- With SYSREG_WRITE_LOG_EN: 5 writes -> 0x10 reads 0x84; reading 0x11 then 0x12 returns the first write's addr/data, after which count = 3; write 0x10 -> reads 0x00.

Source files
------------

// File: rtl/sysreg_pkg.sv
// Shared register map, status bit positions and write-log entry type for sysreg_bank.
// Read by the top and by the optional write-log FIFO (SYSREG_WRITE_LOG_EN).
package sysreg_pkg;

    localparam logic [4:0] REG_ID0          = 5'h00;
    localparam logic [4:0] REG_ID1          = 5'h01;
    localparam logic [4:0] REG_FEAT         = 5'h03;
    localparam logic [4:0] REG_LADDR        = 5'h04;
    localparam logic [4:0] REG_LDATA        = 5'h05;
    localparam logic [4:0] REG_STATUS       = 5'h06;
    localparam logic [4:0] REG_WCNT         = 5'h07;
    localparam logic [4:0] REG_SCRATCH_BASE = 5'h08;
    localparam logic [4:0] REG_LOG_STAT     = 5'h10;
    localparam logic [4:0] REG_LOG_ADDR     = 5'h11;
    localparam logic [4:0] REG_LOG_DATA     = 5'h12;

    localparam int STATUS_FEAT_LOCKED  = 0;
    localparam int STATUS_SOFT_RESET   = 1;
    localparam int STATUS_LOG_NONEMPTY = 2;

    localparam int LOG_DEPTH = 4;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } log_entry_t;

endpackage

// File: rtl/sysreg_bank_if.sv
// Host-side register bus for sysreg_bank.
// The host bus decoder drives single-cycle strobes; d_q is the registered read data.
interface sysreg_bank_if #(parameter int ADDR_W = 5);
    logic [ADDR_W-1:0] a;
    logic [7:0]        d_d;
    logic [7:0]        d_q;
    logic              read_strobe;
    logic              write_strobe;

    modport master (output a, d_d, read_strobe, write_strobe, input d_q);
    modport slave  (input a, d_d, read_strobe, write_strobe, output d_q);
endinterface

// File: rtl/sysreg_write_log.sv
// Four-deep FIFO of recent writes with sticky overflow and synchronous clear.
// Instantiated by sysreg_bank only when SYSREG_WRITE_LOG_EN is defined.
module sysreg_write_log
    import sysreg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  log_entry_t push_entry,
    output log_entry_t head,
    output logic [2:0] count,
    output logic       overflow
);

    log_entry_t mem [LOG_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic       do_pop;
    logic       do_push;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted then.
    assign do_pop  = pop && (count != 3'd0);
    assign do_push = push && ((count != 3'(LOG_DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
            count <= count + 3'(do_push) - 3'(do_pop);
        end
    end

endmodule

// File: rtl/sysreg_bank.sv
// Byte-wide per-core system register bank: IDs, scratch, write-once feature enables,
// keyed soft-reset pulse and write tracking. Optional write log under SYSREG_WRITE_LOG_EN.
module sysreg_bank
    import sysreg_pkg::*;
#(
    parameter int              ADDR_W        = 5,
    parameter int              NUM_SCRATCH   = 4,
    parameter logic [7:0]      ID0           = 8'h42,
    parameter logic [7:0]      ID1           = 8'h73,
    parameter logic [7:0]      RST_KEY       = 8'h52,
    parameter int              RST_PULSE_LEN = 16,
    parameter int              FEAT_W        = 8,
    parameter logic [FEAT_W-1:0] FEAT_RESET  = '0
) (
    input  logic              clk,
    input  logic              reset,
    sysreg_bank_if.slave      bus,
    output logic [FEAT_W-1:0] feature_enable,
    output logic              soft_reset
);

    logic [4:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] scratch [NUM_SCRATCH];
    logic       feat_locked;
    logic [4:0] last_addr;
    logic [7:0] last_data;
    logic [7:0] wcount;
    logic [7:0] pulse_cnt;
    logic [7:0] rdata;
    logic       log_nonempty;
    logic [7:0] log_stat_rd;
    logic [7:0] log_addr_rd;
    logic [7:0] log_data_rd;

    assign addr = bus.a[4:0];
    assign rd   = bus.read_strobe;
    assign wr   = bus.write_strobe;

    // Address bits above a[4] are deliberately ignored.
    if (ADDR_W > 5) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.a[ADDR_W-1:5];
    end

`ifdef SYSREG_WRITE_LOG_EN
    log_entry_t log_head;
    log_entry_t log_push_entry;
    logic [2:0] log_count;
    logic       log_overflow;

    assign log_push_entry = '{addr: addr, data: bus.d_d};

    sysreg_write_log u_write_log (
        .clk        (clk),
        .reset      (reset),
        .clear      (wr && (addr == REG_LOG_STAT)),
        .push       (wr && (addr != REG_LOG_STAT)),
        .pop        (rd && (addr == REG_LOG_DATA)),
        .push_entry (log_push_entry),
        .head       (log_head),
        .count      (log_count),
        .overflow   (log_overflow)
    );

    assign log_nonempty = (log_count != 3'd0);
    assign log_stat_rd  = {log_overflow, 4'b0000, log_count};
    assign log_addr_rd  = {3'b000, log_head.addr};
    assign log_data_rd  = log_nonempty ? log_head.data : 8'hFF;
`else
    assign log_nonempty = 1'b0;
    assign log_stat_rd  = 8'hFF;
    assign log_addr_rd  = 8'hFF;
    assign log_data_rd  = 8'hFF;
`endif

    always_comb begin
        rdata = 8'hFF;
        case (addr)
            REG_ID0:      rdata = ID0;
            REG_ID1:      rdata = ID1;
            REG_FEAT:     rdata = 8'(feature_enable);
            REG_LADDR:    rdata = {3'b000, last_addr};
            REG_LDATA:    rdata = last_data;
            REG_STATUS: begin
                rdata = 8'h00;
                rdata[STATUS_FEAT_LOCKED]  = feat_locked;
                rdata[STATUS_SOFT_RESET]   = soft_reset;
                rdata[STATUS_LOG_NONEMPTY] = log_nonempty;
            end
            REG_WCNT:     rdata = wcount;
            REG_LOG_STAT: rdata = log_stat_rd;
            REG_LOG_ADDR: rdata = log_addr_rd;
            REG_LOG_DATA: rdata = log_data_rd;
            default:      rdata = 8'hFF;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (addr == REG_SCRATCH_BASE + 5'(i)) begin
                rdata = scratch[i];
            end
        end
    end

    // soft_reset follows the counter one edge late, so the pulse starts the edge after the key write.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.d_q        <= 8'hFF;
            feature_enable <= FEAT_RESET;
            feat_locked    <= 1'b0;
            soft_reset     <= 1'b0;
            pulse_cnt      <= 8'd0;
            last_addr      <= 5'd0;
            last_data      <= 8'd0;
            wcount         <= 8'd0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= 8'd0;
            end
        end else begin
            if (rd) begin
                bus.d_q <= rdata;
            end
            soft_reset <= (pulse_cnt != 8'd0);
            if (wr && (addr == REG_ID0) && (bus.d_d == RST_KEY)) begin
                pulse_cnt <= 8'(RST_PULSE_LEN);
            end else if (pulse_cnt != 8'd0) begin
                pulse_cnt <= pulse_cnt - 8'd1;
            end
            if (wr) begin
                last_addr <= addr;
                last_data <= bus.d_d;
                if (addr == REG_WCNT) begin
                    wcount <= 8'd0;
                end else if (wcount != 8'hFF) begin
                    wcount <= wcount + 8'd1;
                end
                if ((addr == REG_ID1) && !feat_locked) begin
                    feature_enable <= bus.d_d[FEAT_W-1:0];
                    feat_locked    <= 1'b1;
                end
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (addr == REG_SCRATCH_BASE + 5'(i)) begin
                        scratch[i] <= bus.d_d;
                    end
                end
            end
        end
    end

endmodule
